mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-port data SRAM between the instruction-fetch stage and the MEM-stage load/store path. Each cycle it grants at most one requester and drives the SRAM command: chip select, word address, byte-lane write enables from the memory-op encoding, and lane-replicated write data. It tracks outstanding reads so the SRAM's one-cycle read data is returned to the requester that issued it. An age counter bounds fetch starvation under back-to-back data traffic.

## Interface
- `STARVE_MAX`, default 4: consecutive cycles a waiting fetch may lose to data before fetch is forced to win; legal range 1..15.
- `ADDR_W`, default 14: SRAM word-address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch read request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch byte address, word-aligned.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` valid (registered ownership).
- `if_rdata`  out  32  raw SRAM word.
- `d_req`  in  1  data request; held with op, address and data until `d_gnt`.
- `d_op`  in  5  mem-op: [4:3] read/write class, [1:0] byte/half/word size.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data, right-justified.
- `d_gnt`  out  1  data accepted this cycle (combinational).
- `d_err`  out  1  pulses with `d_gnt` on a misaligned access.
- `d_rvalid`  out  1  `d_rdata` valid.
- `d_rdata`  out  32  raw SRAM word; sub-word extraction happens downstream.
- `sram_cs`  out  1  access this cycle.
- `sram_addr`  out  `ADDR_W`  word address = byte address [`ADDR_W`+1:2].
- `sram_wen`  out  4  byte-lane write enables; 0 means read.
- `sram_din`  out  32  write data.
- `sram_dout`  in  32  read data, valid the cycle after a read with `sram_cs`.

## Operation
- Arbitration: data wins by default. Fetch wins only when `if_req` is high and `starve_cnt == STARVE_MAX`. A lone requester always wins.
- `starve_cnt` (4 bits) increments, saturating at `STARVE_MAX`, when `if_req` is high and `if_gnt` is low. It clears when `if_gnt` is high or `if_req` is low.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0. It is granted with `d_err` high, `sram_cs`=0, and no rvalid follows.
- Writes, when `d_op[4:3]` is the write class:
  - byte: `sram_wen = 4'b0001 << addr[1:0]`, data byte replicated on all 4 lanes.
  - half: `sram_wen = 4'b0011 << {addr[1],1'b0}`, data halfword replicated on both halves.
  - word: `sram_wen = 4'b1111`, data as is.
  - unknown size: `sram_wen = 0` with `sram_cs = 0` (no-op, still granted).
- Reads: `sram_wen = 0`. Data ops that are neither read nor write class are granted with no SRAM access.
- Return FSM, states IDLE / RD_IF / RD_D:
  - next state is RD_IF if a fetch read was issued, RD_D if a data read was issued, otherwise IDLE.
  - in RD_IF, `if_rvalid`=1 and `if_rdata = sram_dout`; in RD_D the same for the data port.
  - rdata outputs are 0 when the matching rvalid is low.
- Back-to-back accesses are fully pipelined: a new access issues in the same cycle as the previous read's return.

## Timing
- Grant and SRAM command are combinational from requests plus registered `starve_cnt`: zero-cycle issue.
- Read latency: rvalid exactly 1 cycle after the grant cycle. Writes complete at the issuing edge with no response.
- Throughput: one access per cycle.
- Reset (`rst_n` low):
  - state forced to IDLE and `starve_cnt` to 0.
  - all grants, `d_err`, `sram_cs`, `sram_wen`, both rvalids and both rdata outputs are held at 0 regardless of requests.
  - a read issued the cycle before reset asserts never returns.
  - first grant is possible in the cycle after `rst_n` deasserts.
- Simultaneous `if_req` and `d_req` with `starve_cnt == STARVE_MAX`: fetch wins, counter clears, data waits exactly one cycle.

## Structure
- Shared package `mem_pkg`:
  - mem-op class and size constants: `MEM_READ`, `MEM_WRITE`, `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`.
  - `ret_state_t` enum for IDLE/RD_IF/RD_D.
- Sub-module `mem_lane_gen`: combinational; maps op, addr[1:0] and wdata to `sram_wen`, `sram_din` and the misalign flag.
- Arbitration, starvation counter and return FSM stay in the top module.

## Test plan
- Fetch-only read at 0x100 with SRAM word 0xDEADBEEF: `if_gnt` in cycle 0, `sram_addr`=0x40; `if_rvalid` with 0xDEADBEEF in cycle 1.
- Data byte store of 0x000000AB to 0x203: `sram_wen`=4'b1000, `sram_din`=0xABABABAB, no rvalid.
- Half store to 0x202: `sram_wen`=4'b1100. Word store to 0x201: `d_err`=1, `sram_cs`=0.
- Both requesters held high continuously with `STARVE_MAX`=4: data granted 4 cycles, fetch in the 5th, then data again; fetch never waits more than 5 cycles.
- Data read then fetch read on consecutive cycles: `d_rvalid` in cycle 1 and `if_rvalid` in cycle 2, each carrying its own SRAM word.
- Assert `rst_n` low the cycle after a data read grant: no `d_rvalid` ever appears, and all outputs are 0 during reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared mem-op encodings and return-state type for the data SRAM port.
package mem_pkg;

   // d_op[4:3] access class
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   // d_op[1:0] access size; 2'b11 is an unknown size
   localparam logic [1:0] MEM_BYTE  = 2'b00;
   localparam logic [1:0] MEM_HALF  = 2'b01;
   localparam logic [1:0] MEM_WORD  = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RD_IF = 2'b01,
      RD_D  = 2'b10
   } ret_state_t;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane write enables, lane-replicated store data and alignment check.
module mem_lane_gen
   import mem_pkg::*;
(
   input  logic [1:0]  op_cls,
   input  logic [1:0]  op_size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  wen,
   output logic [31:0] din,
   output logic        misalign
);

   always_comb begin
      wen      = '0;
      din      = wdata;
      misalign = 1'b0;

      if (op_cls == MEM_READ || op_cls == MEM_WRITE) begin
         case (op_size)
            MEM_HALF: misalign = addr_lo[0];
            MEM_WORD: misalign = |addr_lo;
            default:  misalign = 1'b0;
         endcase
      end

      if (op_cls == MEM_WRITE && !misalign) begin
         case (op_size)
            MEM_BYTE: begin
               wen = 4'b0001 << addr_lo;
               din = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
               wen = 4'b0011 << {addr_lo[1], 1'b0};
               din = {2{wdata[15:0]}};
            end
            MEM_WORD: wen = '1;
            default:  wen = '0;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-port data SRAM with bounded fetch starvation
// and one-cycle read-return steering.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned ADDR_W     = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic [4:0]        d_op,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_err,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              sram_cs,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [3:0]        sram_wen,
   output logic [31:0]       sram_din,
   input  logic [31:0]       sram_dout
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   ret_state_t  state, nxt_state;
   logic [3:0]  starve_cnt;
   logic [3:0]  lane_wen;
   logic [31:0] lane_din;
   logic        lane_misalign;
   logic        if_win;
   logic        d_rd, d_wr;
   logic        unused_bits;

   assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_op[2]};

   mem_lane_gen u_lane (
      .op_cls   (d_op[4:3]),
      .op_size  (d_op[1:0]),
      .addr_lo  (d_addr[1:0]),
      .wdata    (d_wdata),
      .wen      (lane_wen),
      .din      (lane_din),
      .misalign (lane_misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state <= nxt_state;
         if (!if_req || if_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_comb begin
      nxt_state = IDLE;
      if_win    = 1'b0;
      d_rd      = 1'b0;
      d_wr      = 1'b0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      d_err     = 1'b0;
      sram_cs   = 1'b0;
      sram_addr = '0;
      sram_wen  = '0;
      sram_din  = '0;

      // Grants are gated by rst_n so nothing issues while reset is held.
      if (rst_n) begin
         d_rd   = (d_op[4:3] == MEM_READ);
         d_wr   = (d_op[4:3] == MEM_WRITE);
         if_win = if_req && (!d_req || starve_cnt == SMAX);
         if (if_win) begin
            if_gnt    = 1'b1;
            sram_cs   = 1'b1;
            sram_addr = if_addr[ADDR_W+1:2];
            nxt_state = RD_IF;
         end else if (d_req) begin
            d_gnt = 1'b1;
            d_err = lane_misalign;
            if (!lane_misalign) begin
               if (d_rd) begin
                  sram_cs   = 1'b1;
                  sram_addr = d_addr[ADDR_W+1:2];
                  nxt_state = RD_D;
               end else if (d_wr && lane_wen != 4'b0000) begin
                  sram_cs   = 1'b1;
                  sram_addr = d_addr[ADDR_W+1:2];
                  sram_wen  = lane_wen;
                  sram_din  = lane_din;
               end
            end
         end
      end

      if_rvalid = (state == RD_IF);
      d_rvalid  = (state == RD_D);
      if_rdata  = if_rvalid ? sram_dout : '0;
      d_rdata   = d_rvalid  ? sram_dout : '0;
   end

endmodule
